// File: rtl/ws2812_frame_driver.sv
// WS2812 strip driver: holds 2**AW colours and serialises them as GRB frames followed by a latch-low gap.
// Define WS2812_BRIGHTNESS_EN to add the brightness port and per-channel scaling at LED load.
module ws2812_frame_driver #(
    parameter int AW      = 3,
    parameter int BIT_CYC = 128,
    parameter int T0H_CYC = 40,
    parameter int T1H_CYC = 80,
    parameter int RES_CYC = 28100
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [23:0]   wr_data,
    input  logic [AW:0]   num_leds,
    input  logic          go,
`ifdef WS2812_BRIGHTNESS_EN
    input  logic [7:0]    brightness,
`endif
    output logic          data_out,
    output logic          ready,
    output logic          frame_done
);

    localparam int DEPTH = 1 << AW;
    localparam int LW    = AW + 1;
    localparam int BCW   = $clog2(BIT_CYC + 1);
    localparam int RCW   = $clog2(RES_CYC + 1);

    localparam logic [LW-1:0]  MAX_LEDS = LW'(DEPTH);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(BIT_CYC - 1);
    localparam logic [BCW-1:0] T0H      = BCW'(T0H_CYC);
    localparam logic [BCW-1:0] T1H      = BCW'(T1H_CYC);
    localparam logic [RCW-1:0] RES_LAST = RCW'(RES_CYC - 1);

    typedef enum logic [1:0] {IDLE, SEND, LATCH} stateT;

    stateT          state, stateNext;
    logic [BCW-1:0] bitCnt, bitCntNext;
    logic [4:0]     bitIdx, bitIdxNext;
    logic [LW-1:0]  ledIdx, ledIdxNext;
    logic [LW-1:0]  ledCount, ledCountNext;
    logic [RCW-1:0] resCnt, resCntNext;
    logic [23:0]    shiftReg, shiftNext;
    logic           dataNext, doneNext;
    logic [BCW-1:0] highLen;

    logic [23:0]    mem [DEPTH];
    logic [AW-1:0]  loadAddr;
    logic [23:0]    rawWord;
    logic [23:0]    loadWord;
    logic [LW-1:0]  clampedLeds;

    // Handshake: go is taken on a rising edge where go=1 and ready=1; ready falls the
    // following cycle and rises again on the same edge that frame_done pulses.
    assign ready = (state == IDLE);

    assign clampedLeds = (num_leds > MAX_LEDS) ? MAX_LEDS : num_leds;

    // The word is sampled on the edge that starts an LED, so a write landing on that
    // same edge is not seen until the next frame.
    assign loadAddr = (state == IDLE) ? '0 : ledIdx[AW-1:0] + AW'(1);
    assign rawWord  = mem[loadAddr];

`ifdef WS2812_BRIGHTNESS_EN
    function automatic logic [7:0] scaleChan(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, b} + 16'd1);
        return prod[15:8];
    endfunction

    assign loadWord = {scaleChan(rawWord[15:8], brightness),
                       scaleChan(rawWord[23:16], brightness),
                       scaleChan(rawWord[7:0], brightness)};
`else
    assign loadWord = {rawWord[15:8], rawWord[23:16], rawWord[7:0]};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bitCnt     <= '0;
            bitIdx     <= '0;
            ledIdx     <= '0;
            ledCount   <= '0;
            resCnt     <= '0;
            shiftReg   <= '0;
            data_out   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= stateNext;
            bitCnt     <= bitCntNext;
            bitIdx     <= bitIdxNext;
            ledIdx     <= ledIdxNext;
            ledCount   <= ledCountNext;
            resCnt     <= resCntNext;
            shiftReg   <= shiftNext;
            data_out   <= dataNext;
            frame_done <= doneNext;
        end
    end

    always_comb begin
        stateNext    = state;
        bitCntNext   = bitCnt;
        bitIdxNext   = bitIdx;
        ledIdxNext   = ledIdx;
        ledCountNext = ledCount;
        resCntNext   = resCnt;
        shiftNext    = shiftReg;
        case (state)
            IDLE: begin
                if (go) begin
                    ledCountNext = clampedLeds;
                    ledIdxNext   = '0;
                    bitCntNext   = '0;
                    bitIdxNext   = '0;
                    resCntNext   = '0;
                    if (clampedLeds == '0) begin
                        stateNext = LATCH;
                    end else begin
                        stateNext = SEND;
                        shiftNext = loadWord;
                    end
                end
            end
            SEND: begin
                if (bitCnt == BIT_LAST) begin
                    bitCntNext = '0;
                    if (bitIdx == 5'd23) begin
                        bitIdxNext = '0;
                        if (ledIdx == ledCount - LW'(1)) begin
                            stateNext  = LATCH;
                            resCntNext = '0;
                        end else begin
                            ledIdxNext = ledIdx + LW'(1);
                            shiftNext  = loadWord;
                        end
                    end else begin
                        bitIdxNext = bitIdx + 5'd1;
                        shiftNext  = {shiftReg[22:0], 1'b0};
                    end
                end else begin
                    bitCntNext = bitCnt + BCW'(1);
                end
            end
            LATCH: begin
                if (resCnt == RES_LAST) begin
                    stateNext = IDLE;
                end else begin
                    resCntNext = resCnt + RCW'(1);
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so the strip line never glitches.
    always_comb begin
        highLen  = shiftNext[23] ? T1H : T0H;
        dataNext = (stateNext == SEND) && (bitCntNext < highLen);
        doneNext = (state == LATCH) && (stateNext == IDLE);
    end

endmodule

// File: tb/tb_ws2812_frame_driver.sv
// Directed bench for ws2812_frame_driver: one instance at default timing, one with short timing.
// Define WS2812_BRIGHTNESS_EN to include the brightness steps.
module tb_ws2812_frame_driver;

    localparam int AW    = 3;
    localparam int S_BIT = 16;
    localparam int S_T0H = 5;
    localparam int S_T1H = 10;
    localparam int S_RES = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetA, resetS, goA, goS, wr_en;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;
    logic [AW:0]   num_leds;
`ifdef WS2812_BRIGHTNESS_EN
    logic [7:0]    brightness;
`endif
    logic          doA, doS, readyA, readyS, fdA, fdS;
    logic          sel;

    wire dOut  = sel ? doS : doA;
    wire ready = sel ? readyS : readyA;
    wire fd    = sel ? fdS : fdA;

    int nCompared   = 0;
    int nMismatched = 0;
    int smp;
    int schedAt;
    logic [AW-1:0] schedAddr;
    logic [23:0]   schedData;

    ws2812_frame_driver dutA (
        .clk(clk), .reset(resetA), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_leds(num_leds), .go(goA),
`ifdef WS2812_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .data_out(doA), .ready(readyA), .frame_done(fdA)
    );

    ws2812_frame_driver #(
        .AW(AW), .BIT_CYC(S_BIT), .T0H_CYC(S_T0H), .T1H_CYC(S_T1H), .RES_CYC(S_RES)
    ) dutS (
        .clk(clk), .reset(resetS), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_leds(num_leds), .go(goS),
`ifdef WS2812_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .data_out(doS), .ready(readyS), .frame_done(fdS)
    );

    function automatic int bitCyc(); return sel ? S_BIT : 128; endfunction
    function automatic int t0h();    return sel ? S_T0H : 40;  endfunction
    function automatic int t1h();    return sel ? S_T1H : 80;  endfunction

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic writeLed(input logic [AW-1:0] a, input logic [23:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Called at a negedge; returns at the first negedge after the acceptance edge.
    task automatic acceptGo(input logic wrNow, input logic [AW-1:0] a, input logic [23:0] d);
        if (sel) goS = 1'b1; else goA = 1'b1;
        if (wrNow) begin wr_en = 1'b1; wr_addr = a; wr_data = d; end
        @(negedge clk);
        goA = 1'b0; goS = 1'b0; wr_en = 1'b0;
        smp = 1;
        check("ready_drop", ready, 0);
    endtask

    task automatic captureBits(input int nBits, output logic [191:0] stream, output int bad);
        int h;
        stream = '0;
        bad = 0;
        for (int b = 0; b < nBits; b++) begin
            h = 0;
            for (int c = 0; c < bitCyc(); c++) begin
                if (dOut) begin
                    if (c != h) bad++;
                    h++;
                end
                wr_en = (smp == schedAt);
                if (smp == schedAt) begin wr_addr = schedAddr; wr_data = schedData; end
                @(negedge clk);
                smp++;
            end
            if (h != t0h() && h != t1h()) bad++;
            stream = {stream[190:0], (h == t1h())};
        end
        wr_en = 1'b0;
    endtask

    task automatic waitDone(input int budget, output int n, output int highs);
        n = 0;
        highs = 0;
        while (!fd && n < budget) begin
            if (dOut) highs++;
            @(negedge clk);
            n++;
        end
        check("done_seen", fd, 1);
        check("ready_at_done", ready, 1);
        @(negedge clk);
        check("done_one_cycle", fd, 0);
    endtask

    task automatic countDone(input int win, input int goAt, output int first, output int pulses);
        first = -1;
        pulses = 0;
        for (int s = 1; s <= win; s++) begin
            if (fd) begin
                pulses++;
                if (first < 0) first = s;
            end
            if (s == goAt) begin
                check("ready_busy", ready, 0);
                goS = 1'b1;
            end else begin
                goS = 1'b0;
            end
            @(negedge clk);
        end
        goS = 1'b0;
    endtask

    initial begin
        logic [191:0] stream;
        int bad, n, highs, first, pulses;

        resetA = 1'b1; resetS = 1'b1; goA = 1'b0; goS = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; num_leds = '0;
`ifdef WS2812_BRIGHTNESS_EN
        brightness = 8'hFF;
`endif
        sel = 1'b0; schedAt = -1; schedAddr = '0; schedData = '0; smp = 0;
        repeat (3) @(negedge clk);
        resetA = 1'b0; resetS = 1'b0;

        check("rst_data_a", doA, 0);
        check("rst_ready_a", readyA, 1);
        check("rst_done_a", fdA, 0);
        check("rst_data_s", doS, 0);
        check("rst_ready_s", readyS, 1);
        check("rst_done_s", fdS, 0);

        // Single red LED at default timing.
        writeLed(0, 24'hFF0000);
        num_leds = 4'd1;
        acceptGo(1'b0, '0, '0);
        captureBits(24, stream, bad);
        check("red_stream", stream, 24'h00FF00);
        check("red_shape", bad, 0);
        waitDone(30000, n, highs);
        check("red_latch_len", n, 28100);
        check("red_latch_low", highs, 0);
        check("red_frame_len", 24 * 128 + n, 31172);

        // Empty frame: straight to latch.
        num_leds = 4'd0;
        acceptGo(1'b0, '0, '0);
        waitDone(30000, n, highs);
        check("empty_latch_len", n, 28100);
        check("empty_line_low", highs, 0);

        sel = 1'b1;

        // Three LEDs, GRB order.
        writeLed(0, 24'h010203);
        writeLed(1, 24'h0A0B0C);
        writeLed(2, 24'hFFFFFF);
        num_leds = 4'd3;
        acceptGo(1'b0, '0, '0);
        captureBits(72, stream, bad);
        check("three_stream", stream, 72'h020103_0B0A0C_FFFFFF);
        check("three_shape", bad, 0);
        waitDone(200, n, highs);
        check("three_latch_len", n, S_RES);

        // Oversized count clamps to the 8-entry buffer.
        writeLed(3, 24'h112233);
        writeLed(4, 24'h445566);
        writeLed(5, 24'h778899);
        writeLed(6, 24'hAABBCC);
        writeLed(7, 24'hDDEEF0);
        num_leds = 4'd15;
        acceptGo(1'b0, '0, '0);
        captureBits(192, stream, bad);
        check("clamp_stream", stream,
              192'h020103_0B0A0C_FFFFFF_221133_554466_887799_BBAACC_EEDDF0);
        check("clamp_shape", bad, 0);
        waitDone(200, n, highs);
        check("clamp_latch_len", n, S_RES);

        // go while busy is ignored; num_leds change after acceptance has no effect.
        num_leds = 4'd1;
        acceptGo(1'b0, '0, '0);
        num_leds = 4'd5;
        countDone(600, 10, first, pulses);
        check("busy_go_done_at", first, 24 * S_BIT + S_RES + 1);
        check("busy_go_pulses", pulses, 1);

        // Reset during bit 5 of a frame aborts it.
        writeLed(0, 24'h00FF00);
        num_leds = 4'd1;
        acceptGo(1'b0, '0, '0);
        repeat (5 * S_BIT) @(negedge clk);
        check("bit5_high", dOut, 1);
        resetS = 1'b1;
        @(negedge clk);
        check("abort_data", dOut, 0);
        check("abort_ready", ready, 1);
        check("abort_done", fd, 0);
        resetS = 1'b0;
        countDone(600, 0, first, pulses);
        check("abort_no_done", pulses, 0);

        // Write races: addr0 on its load edge keeps old data, addr1 mid-LED0 takes effect.
        writeLed(0, 24'h123456);
        writeLed(1, 24'hABCDEF);
        num_leds = 4'd2;
        schedAt = 5; schedAddr = 3'd1; schedData = 24'h13579B;
        acceptGo(1'b1, 3'd0, 24'h654321);
        captureBits(48, stream, bad);
        schedAt = -1;
        check("race_stream", stream, 48'h341256_57139B);
        check("race_shape", bad, 0);
        waitDone(200, n, highs);
        check("race_latch_len", n, S_RES);

`ifdef WS2812_BRIGHTNESS_EN
        writeLed(0, 24'hFFFFFF);
        num_leds = 4'd1;
        brightness = 8'h7F;
        acceptGo(1'b0, '0, '0);
        captureBits(24, stream, bad);
        check("bright_7f_stream", stream, 24'h7F7F7F);
        check("bright_7f_shape", bad, 0);
        waitDone(200, n, highs);
        brightness = 8'h00;
        acceptGo(1'b0, '0, '0);
        captureBits(24, stream, bad);
        check("bright_00_stream", stream, 24'h000000);
        check("bright_00_shape", bad, 0);
        waitDone(200, n, highs);
        brightness = 8'hFF;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/ws2812_frame_driver.md
WS2812_FRAME_DRIVER -- requirements
Module: ws2812_frame_driver

Interface
REQ-001 SHALL have parameter AW, default 3, LED buffer address width; buffer depth 2**AW.
REQ-002 SHALL have parameter BIT_CYC, default 128, clocks per data bit (1280 ns at 100 MHz).
REQ-003 SHALL have parameter T0H_CYC, default 40, high clocks for a 0 bit.
REQ-004 SHALL have parameter T1H_CYC, default 80, high clocks for a 1 bit.
REQ-005 SHALL have parameter RES_CYC, default 28100, latch-low clocks (281,000 ns at 100 MHz).
REQ-006 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port wr_en  input  1  buffer write strobe.
REQ-009 SHALL have port wr_addr  input  AW  buffer write address (LED index).
REQ-010 SHALL have port wr_data  input  24  colour {R[23:16],G[15:8],B[7:0]}.
REQ-011 SHALL have port num_leds  input  AW+1  LEDs per frame.
REQ-012 SHALL have port go  input  1  frame start request.
REQ-013 SHALL have port brightness  input  8  global scale; present only with WS2812_BRIGHTNESS_EN.
REQ-014 SHALL have port data_out  output  1  serial line to strip.
REQ-015 SHALL have port ready  output  1  idle, can accept go.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse at frame end.

Function
REQ-017 SHALL implement states IDLE, SEND, LATCH; IDLE->SEND (or LATCH if LED count 0) on go=1 while ready=1; SEND->LATCH after last bit of last LED; LATCH->IDLE after RES_CYC clocks.
REQ-018 SHALL snapshot num_leds at go acceptance, clamped to 2**AW; later num_leds changes not affect the current frame.
REQ-019 SHALL drop ready on the cycle after go acceptance and raise it on the same edge frame_done pulses; go while ready=0 ignored.
REQ-020 SHALL send LEDs in address order 0..N-1, 24 bits each, order G7..G0, R7..R0, B7..B0 (MSB first).
REQ-021 SHALL drive each bit for exactly BIT_CYC clocks: data_out=1 for first T1H_CYC (bit 1) or T0H_CYC (bit 0) clocks, 0 for remainder; no gaps between bits or LEDs.
REQ-022 SHALL load an LED's word into the shift register on that LED's first bit clock; a write to the same address in that cycle SHALL not affect it (old data sent); writes to later LEDs take effect this frame.
REQ-023 SHALL accept buffer writes in any state; wr_en in reset cycle ignored.
REQ-024 SHALL hold data_out=0 in IDLE and LATCH.
REQ-025 SHALL make frame length exactly N*24*BIT_CYC + RES_CYC clocks from the cycle after acceptance to frame_done.

Reset
REQ-026 SHALL on reset: state IDLE, data_out=0, ready=1, frame_done=0, all counters 0, all buffer entries 24'h000000.
REQ-027 SHALL on reset mid-frame abort: data_out=0 on the next edge, no frame_done pulse.

Configuration
REQ-028 SHALL, with WS2812_BRIGHTNESS_EN defined, transmit each 8-bit channel c as (c*(brightness+1))>>8, computed with 16-bit intermediate at LED load (brightness 255 = unchanged, 0 = all zero).
REQ-029 SHALL, without WS2812_BRIGHTNESS_EN, omit the brightness port and transmit channels unmodified.

Verification
REQ-030 SHALL cover: default params, write addr0=24'hFF0000, num_leds=1, go -> 8 bits 40-high, 8 bits 80-high, 8 bits 40-high, low 28100, frame_done 31172 clocks after acceptance, ready=1.
REQ-031 SHALL cover: addr0/1/2 = 24'h010203/24'h0A0B0C/24'hFFFFFF, num_leds=3 -> decoded stream 02,01,03,0B,0A,0C,FF,FF,FF.
REQ-032 SHALL cover: num_leds=0, go -> data_out never high, frame_done after 28100 clocks; num_leds=15 (AW=3) -> exactly 8 LEDs (24576 bit clocks).
REQ-033 SHALL cover: go pulsed during SEND -> ignored, exactly one frame_done; reset during bit 5 -> data_out=0 next cycle, ready=1, no frame_done.
REQ-034 SHALL cover: write addr1 while LED0 shifting -> new addr1 value sent; write addr0 during LED0 load cycle -> old value sent.
REQ-035 SHALL cover: WS2812_BRIGHTNESS_EN, brightness=8'h7F, colour 24'hFFFFFF -> all channels sent as 8'h7F; brightness=8'h00 -> all bits 0.
